// File: rtl/core_ctrl_pkg.sv
// Shared control-path definitions for the MUL/DIV issue/writeback scheduler:
// FSM encoding, default latencies and the WB reservation distance.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WB   = 2'b10
  } md_state_e;

  localparam int MUL_LAT_DEF     = 4;
  localparam int DIV_LAT_DEF     = 34;
  localparam int CNT_W_DEF       = 6;
  // Bubble injected at this count walks EX, MEM and lands in WB at count 0.
  localparam int WB_RESERVE_DIST = 3;

  function automatic logic reg_hit(logic use_r, logic [4:0] a, logic [4:0] b);
    return use_r && (a == b) && (b != 5'd0);
  endfunction

endpackage

// File: rtl/muldiv_sched_ctrl_if.sv
// ID-stage / MUL-DIV unit signal bundle for the scheduler.
// Optional forwarding outputs exist only with MUL_DIV_FWD_EN.
interface muldiv_sched_ctrl_if;
  logic       md_valid_ID;
  logic [2:0] md_funct3_ID;
  logic [4:0] rd_ID, rs1_ID, rs2_ID;
  logic       rs1use_ID, rs2use_ID, wen_ID, ext_stall_ID;

  logic       md_start;
  logic [2:0] md_funct3;
  logic [4:0] md_rd;
  logic       md_busy, stall_ID, bubble_DE, md_rf_we, wb_sel_md;
`ifdef MUL_DIV_FWD_EN
  logic       fwd_md_A, fwd_md_B;
`endif

  modport slave (
    input  md_valid_ID, md_funct3_ID, rd_ID, rs1_ID, rs2_ID,
    input  rs1use_ID, rs2use_ID, wen_ID, ext_stall_ID,
`ifdef MUL_DIV_FWD_EN
    output fwd_md_A, fwd_md_B,
`endif
    output md_start, md_funct3, md_rd, md_busy, stall_ID, bubble_DE,
    output md_rf_we, wb_sel_md
  );

  modport master (
    output md_valid_ID, md_funct3_ID, rd_ID, rs1_ID, rs2_ID,
    output rs1use_ID, rs2use_ID, wen_ID, ext_stall_ID,
`ifdef MUL_DIV_FWD_EN
    input  fwd_md_A, fwd_md_B,
`endif
    input  md_start, md_funct3, md_rd, md_busy, stall_ID, bubble_DE,
    input  md_rf_we, wb_sel_md
  );
endinterface

// File: rtl/md_lat_counter.sv
// Load/decrement latency counter; flags the WB-reservation point and the
// last RUN cycle. Holds at zero when idle.
module md_lat_counter
  import core_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             at_resv,
  output logic             at_last
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign at_resv = (cnt_q == CNT_W'(WB_RESERVE_DIST));
  assign at_last = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/muldiv_sched_ctrl.sv
// MUL/DIV issue and writeback scheduler: starts the shared unit, stalls ID on
// conflicts and reserves the RF write port. MUL_DIV_FWD_EN adds WB-cycle forwarding.
module muldiv_sched_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  muldiv_sched_ctrl_if.slave bus
);
  md_state_e        state_q, state_d;
  logic [4:0]       md_rd_q, md_rd_d;
  logic [2:0]       md_funct3_q, md_funct3_d;
  logic             issue, conflict, resv, at_resv, at_last;
  logic             hit_rs1, hit_rs2, hit_rd, fwd_a, fwd_b;
  logic [CNT_W-1:0] lat_m1;

  assign hit_rs1 = reg_hit(bus.rs1use_ID, bus.rs1_ID, md_rd_q);
  assign hit_rs2 = reg_hit(bus.rs2use_ID, bus.rs2_ID, md_rd_q);
  assign hit_rd  = reg_hit(bus.wen_ID,    bus.rd_ID,  md_rd_q);
  assign lat_m1  = bus.md_funct3_ID[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

  md_lat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (issue),
    .load_val (lat_m1),
    .at_resv  (at_resv),
    .at_last  (at_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      md_rd_q     <= '0;
      md_funct3_q <= '0;
    end else begin
      state_q     <= state_d;
      md_rd_q     <= md_rd_d;
      md_funct3_q <= md_funct3_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    md_rd_d     = issue ? bus.rd_ID        : md_rd_q;
    md_funct3_d = issue ? bus.md_funct3_ID : md_funct3_q;
    case (state_q)
      IDLE:    if (issue) state_d = RUN;
      RUN:     if (at_last) state_d = WB;
      WB:      state_d = issue ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In WB the unit is free again, so only register conflicts hold ID.
  always_comb begin
    conflict = 1'b0;
    resv     = 1'b0;
    fwd_a    = 1'b0;
    fwd_b    = 1'b0;
    case (state_q)
      RUN: begin
        conflict = bus.md_valid_ID | hit_rs1 | hit_rs2 | hit_rd;
        resv     = at_resv;
      end
      WB: begin
`ifdef MUL_DIV_FWD_EN
        conflict = hit_rd;
        fwd_a    = hit_rs1;
        fwd_b    = hit_rs2;
`else
        conflict = hit_rs1 | hit_rs2 | hit_rd;
`endif
      end
      default: ;
    endcase
    issue = bus.md_valid_ID & ~bus.ext_stall_ID & ~conflict;
  end

  assign bus.md_start  = issue;
  assign bus.md_funct3 = md_funct3_q;
  assign bus.md_rd     = md_rd_q;
  assign bus.md_busy   = (state_q != IDLE);
  assign bus.stall_ID  = conflict | resv;
  assign bus.bubble_DE = conflict | resv;
  assign bus.md_rf_we  = (state_q == WB) && (md_rd_q != 5'd0);
  assign bus.wb_sel_md = (state_q == WB);
`ifdef MUL_DIV_FWD_EN
  assign bus.fwd_md_A  = fwd_a;
  assign bus.fwd_md_B  = fwd_b;
`else
  logic unused_fwd;
  assign unused_fwd = fwd_a ^ fwd_b;
`endif
endmodule

// File: tb/tb_muldiv_sched_ctrl.sv
// Self-checking bench for muldiv_sched_ctrl: directed scenarios plus random
// traffic against a cycle-indexed reference model (write at issue cycle + LAT).
module tb_muldiv_sched_ctrl;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 34;
`ifdef MUL_DIV_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  muldiv_sched_ctrl_if bus();

  muldiv_sched_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int t = 0;                        // cycle index, bumped at every posedge
  bit m_busy = 1'b0;
  int m_wr = 0;                     // cycle in which the in-flight result is written
  logic [4:0] m_rd = '0;
  logic [2:0] m_f3 = '0;
  logic e_start, e_stall, e_rfwe, e_wbsel, e_fa, e_fb;

  function automatic logic hit(logic u, logic [4:0] a, logic [4:0] b);
    return u && (a != 0) && (a == b);
  endfunction

  task automatic model_eval();
    bit run, wb, res, h1, h2, hw, conf;
    run = m_busy && (t < m_wr);
    wb  = m_busy && (t == m_wr);
    res = m_busy && (t == m_wr - 3);
    h1  = hit(bus.rs1use_ID, bus.rs1_ID, m_rd);
    h2  = hit(bus.rs2use_ID, bus.rs2_ID, m_rd);
    hw  = hit(bus.wen_ID, bus.rd_ID, m_rd);
    conf = 1'b0;
    if (run)     conf = bus.md_valid_ID | h1 | h2 | hw;
    else if (wb) conf = FWD ? hw : (h1 | h2 | hw);
    e_start = bus.md_valid_ID & ~bus.ext_stall_ID & ~conf;
    e_stall = conf | res;
    e_rfwe  = wb && (m_rd != 0);
    e_wbsel = wb;
    e_fa    = FWD && wb && h1;
    e_fb    = FWD && wb && h2;
  endtask

  task automatic model_adv();
    bit wb;
    model_eval();
    wb = m_busy && (t == m_wr);
    if (!rst_n) begin
      m_busy = 1'b0; m_rd = '0; m_f3 = '0;
    end else if (e_start) begin
      m_busy = 1'b1; m_rd = bus.rd_ID; m_f3 = bus.md_funct3_ID; m_wr = t + (bus.md_funct3_ID[2] ? DIV_LAT : MUL_LAT);
    end else if (wb) begin
      m_busy = 1'b0;
    end
    t++;
  endtask

  function automatic logic [15:0] obs_v();
    logic fa, fb;
    fa = 1'b0; fb = 1'b0;
`ifdef MUL_DIV_FWD_EN
    fa = bus.fwd_md_A; fb = bus.fwd_md_B;
`endif
    return {bus.md_start, bus.md_busy, bus.stall_ID, bus.bubble_DE, bus.md_rf_we,
            bus.wb_sel_md, bus.md_rd, bus.md_funct3, fa, fb};
  endfunction

  function automatic logic [15:0] exp_v();
    return {e_start, m_busy, e_stall, e_stall, e_rfwe, e_wbsel, m_rd, m_f3, e_fa, e_fb};
  endfunction

  task automatic set_id(input logic v, input logic [2:0] f3, input logic [4:0] rd, rs1, rs2,
                        input logic u1, u2, w, ext);
    bus.md_valid_ID = v; bus.md_funct3_ID = f3; bus.rd_ID = rd; bus.rs1_ID = rs1; bus.rs2_ID = rs2;
    bus.rs1use_ID = u1; bus.rs2use_ID = u2; bus.wen_ID = w; bus.ext_stall_ID = ext;
  endtask

  task automatic idle_in(); set_id(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  task automatic tick(); @(posedge clk); model_adv(); #1; endtask

  task automatic drain();
    idle_in();
    for (int i = 0; i < DIV_LAT + 5 && bus.md_busy; i++) tick();
    n_cmp++;
    if (bus.md_busy !== 1'b0) begin n_err++; $display("FAIL drain t=%0d busy=%b want=0", t, bus.md_busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_in();
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk); model_eval(); n_cmp++;
    if (obs_v() !== 16'h0) begin n_err++; $display("FAIL reset got=%h want=%h", obs_v(), 16'h0); end
    tick();
  endtask

  task automatic test_mul_basic();
    int t0, ts, tb, tr;
    t0 = t; ts = -1; tb = -1; tr = -1;
    set_id(1'b1, 3'($urandom_range(0, 3)), 5'd5, 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); model_eval(); n_cmp++;
      if (obs_v() !== exp_v()) begin n_err++; $display("FAIL mul_basic t=%0d got=%h want=%h", t, obs_v(), exp_v()); end
      if (bus.md_start && ts < 0) ts = t;
      if (bus.stall_ID && tb < 0) tb = t;
      if (bus.md_rf_we && bus.md_rd == 5'd5 && tr < 0) tr = t;
      tick(); idle_in();
    end
    n_cmp++;
    if (ts != t0 || tb != t0 + 1 || tr != t0 + MUL_LAT)
      begin n_err++; $display("FAIL mul_timing start/bubble/write got=%0d/%0d/%0d want=%0d/%0d/%0d",
                               ts - t0, tb - t0, tr - t0, 0, 1, MUL_LAT); end
    drain();
  endtask

  task automatic test_div_raw();
    int stalls; bit left, fa_leave;
    stalls = 0; left = 1'b0; fa_leave = 1'b0;
    set_id(1'b1, 3'b100 | 3'($urandom_range(0, 3)), 5'd7, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk); model_eval(); n_cmp++;
    if (obs_v() !== exp_v()) begin n_err++; $display("FAIL div_issue t=%0d got=%h want=%h", t, obs_v(), exp_v()); end
    tick();
    set_id(1'b0, 3'd0, 5'd8, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);   // ADD x8,x7,x1
    for (int i = 0; i < 60 && !left; i++) begin
      @(negedge clk); model_eval(); n_cmp++;
      if (obs_v() !== exp_v()) begin n_err++; $display("FAIL div_raw t=%0d got=%h want=%h", t, obs_v(), exp_v()); end
      if (bus.stall_ID) stalls++;
      else begin
        left = 1'b1;
`ifdef MUL_DIV_FWD_EN
        fa_leave = bus.fwd_md_A;
`endif
      end
      tick();
    end
    n_cmp++;
    if (!left || stalls != (FWD ? DIV_LAT - 1 : DIV_LAT) || fa_leave != FWD)
      begin n_err++; $display("FAIL div_raw_stall left=%b stalls=%0d fwdA=%b want 1/%0d/%b",
                               left, stalls, fa_leave, FWD ? DIV_LAT - 1 : DIV_LAT, FWD); end
    drain();
  endtask

  task automatic test_back_to_back();
    int t0, s2, w2;
    t0 = t; s2 = -1; w2 = -1;
    set_id(1'b1, 3'b000, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk); model_eval(); n_cmp++;
    if (obs_v() !== exp_v()) begin n_err++; $display("FAIL b2b_first t=%0d got=%h want=%h", t, obs_v(), exp_v()); end
    tick();
    set_id(1'b1, 3'b001, 5'd4, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && s2 < 0; i++) begin
      @(negedge clk); model_eval(); n_cmp++;
      if (obs_v() !== exp_v()) begin n_err++; $display("FAIL b2b_hold t=%0d got=%h want=%h", t, obs_v(), exp_v()); end
      if (bus.md_start) s2 = t;
      tick();
    end
    idle_in();
    for (int i = 0; i < 12 && w2 < 0; i++) begin
      @(negedge clk); model_eval(); n_cmp++;
      if (obs_v() !== exp_v()) begin n_err++; $display("FAIL b2b_run t=%0d got=%h want=%h", t, obs_v(), exp_v()); end
      if (bus.md_rf_we && bus.md_rd == 5'd4) w2 = t;
      tick();
    end
    n_cmp++;
    if (s2 != t0 + MUL_LAT || w2 != t0 + 2 * MUL_LAT)
      begin n_err++; $display("FAIL b2b_timing start2/write2 got=%0d/%0d want=%0d/%0d",
                               s2 - t0, w2 - t0, MUL_LAT, 2 * MUL_LAT); end
    drain();
  endtask

  task automatic test_reset_mid();
    int we_cnt, t1, s, w;
    we_cnt = 0; s = -1; w = -1;
    set_id(1'b1, 3'b101, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); model_eval(); n_cmp++;
      if (obs_v() !== exp_v()) begin n_err++; $display("FAIL rstmid_run t=%0d got=%h want=%h", t, obs_v(), exp_v()); end
      tick(); idle_in();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk); model_eval(); n_cmp++;
    if (obs_v() !== 16'h0) begin n_err++; $display("FAIL rstmid_zero got=%h want=%h", obs_v(), 16'h0); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); if (bus.md_rf_we) we_cnt++;
      tick();
    end
    n_cmp++;
    if (we_cnt != 0) begin n_err++; $display("FAIL rstmid_nowrite got=%0d writes want=0", we_cnt); end
    t1 = t;
    set_id(1'b1, 3'b000, 5'd6, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); model_eval(); n_cmp++;
      if (obs_v() !== exp_v()) begin n_err++; $display("FAIL rstmid_mul t=%0d got=%h want=%h", t, obs_v(), exp_v()); end
      if (bus.md_start && s < 0) s = t;
      if (bus.md_rf_we && w < 0) w = t;
      tick(); idle_in();
    end
    n_cmp++;
    if (s != t1 || w != t1 + MUL_LAT)
      begin n_err++; $display("FAIL rstmid_after start/write got=%0d/%0d want=0/%0d", s - t1, w - t1, MUL_LAT); end
    drain();
  endtask

  task automatic test_x0();
    int stalls, we;
    stalls = 0; we = 0;
    set_id(1'b1, 3'b000, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk); model_eval(); n_cmp++;
    if (obs_v() !== exp_v()) begin n_err++; $display("FAIL x0_issue t=%0d got=%h want=%h", t, obs_v(), exp_v()); end
    if (bus.md_rf_we) we++;
    tick();
    set_id(1'b0, 3'd0, 5'd8, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);   // ADD x8,x0,x0
    for (int i = 0; i < MUL_LAT + 2; i++) begin
      @(negedge clk); model_eval(); n_cmp++;
      if (obs_v() !== exp_v()) begin n_err++; $display("FAIL x0_run t=%0d got=%h want=%h", t, obs_v(), exp_v()); end
      if (bus.stall_ID) stalls++;
      if (bus.md_rf_we) we++;
      tick();
    end
    n_cmp++;
    if (stalls != 1 || we != 0) begin n_err++; $display("FAIL x0_summary stalls/writes got=%0d/%0d want=1/0", stalls, we); end
    drain();
  endtask

  task automatic test_ext_stall();
    int starts; logic now;
    starts = 0;
    set_id(1'b1, 3'b010, 5'd11, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); model_eval(); n_cmp++;
      if (obs_v() !== exp_v()) begin n_err++; $display("FAIL ext_hold t=%0d got=%h want=%h", t, obs_v(), exp_v()); end
      if (bus.md_start) starts++;
      tick();
    end
    bus.ext_stall_ID = 1'b0;
    @(negedge clk); model_eval(); now = bus.md_start;
    n_cmp++;
    if (starts != 0 || now !== 1'b1) begin n_err++; $display("FAIL ext_release starts/now got=%0d/%b want=0/1", starts, now); end
    tick();
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      set_id(1'($urandom_range(0, 9) < 4), 3'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0));
      @(negedge clk); model_eval(); n_cmp++;
      if (obs_v() !== exp_v()) begin n_err++; $display("FAIL random t=%0d got=%h want=%h", t, obs_v(), exp_v()); end
      tick();
    end
    rst_n = 1'b1;
    drain();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_mul_basic();
    test_div_raw();
    test_back_to_back();
    test_reset_mid();
    test_x0();
    test_ext_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_sched_ctrl.md
Name: muldiv_sched_ctrl

Overview:
Issue and writeback scheduler for the shared multi-cycle MUL/DIV unit in the 5-stage RISC-V core.
- Accepts M-extension instructions from ID and starts the unit.
- Stalls ID on structural, RAW and WAW conflicts with the in-flight result.
- Reserves the register-file write port by injecting one pipeline bubble timed to reach WB exactly when the result is ready.
- Sits beside the hazard detection unit. Its stall and flush outputs are OR-ed into the pipeline control.

Parameters:
- MUL_LAT, 4, cycles from issue to result for MUL*. Must be >= 4.
- DIV_LAT, 34, cycles from issue to result for DIV*/REM*. Must be >= 4.
- CNT_W, 6, latency counter width. Must satisfy 2^CNT_W > DIV_LAT.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- md_valid_ID  in  1  ID holds a decoded M-extension instruction
- md_funct3_ID  in  3  funct3 of that instruction; bit 2 = div/rem
- rd_ID  in  5  destination of the ID instruction
- rs1_ID, rs2_ID  in  5  source registers of the ID instruction
- rs1use_ID, rs2use_ID  in  1  ID instruction reads rs1 / rs2
- wen_ID  in  1  ID instruction writes rd (any type)
- ext_stall_ID  in  1  stall already requested by the hazard detection unit
- md_start  out  1  one-cycle start pulse to the MUL/DIV unit
- md_funct3  out  3  latched operation for the unit
- md_rd  out  5  destination register of the in-flight op
- md_busy  out  1  an op is in flight (RUN or WB)
- stall_ID  out  1  hold PC and IF/ID
- bubble_DE  out  1  flush ID/EX (insert bubble)
- md_rf_we  out  1  write the MUL/DIV result to the register file this cycle
- wb_sel_md  out  1  steer the register-file write mux to the MUL/DIV result

Behaviour:
- Reset: when rst_n=0 at a posedge, go to IDLE and clear cnt, md_rd and md_funct3. All outputs are 0 in the following cycle. Reset mid-operation abandons the op with no write.
- Issue condition: issue = md_valid_ID & ~ext_stall_ID & ~conflict. md_start = issue.
- On issue at edge S:
  - latch md_rd=rd_ID and md_funct3=md_funct3_ID;
  - cnt = (funct3[2] ? DIV_LAT : MUL_LAT) - 1;
  - go to RUN.
- The issued instruction continues down the pipeline with no register write; the decoder guarantees this.
- FSM IDLE:
  - conflict=0; stall_ID=0.
  - Goes to RUN on issue.
- FSM RUN:
  - cnt decrements by 1 each cycle.
  - conflict = md_valid_ID (structural) | RAW (rs1use_ID & rs1_ID==md_rd, or rs2use_ID & rs2_ID==md_rd) | WAW (wen_ID & rd_ID==md_rd).
  - Any register match where md_rd==0 is ignored.
  - stall_ID = conflict.
  - When cnt==3, force stall_ID=1 and bubble_DE=1 for one cycle (WB reservation). The bubble occupies EX, MEM, then WB in the cycle where cnt==0.
  - Leave RUN for WB when cnt==1.
- FSM WB (cnt==0):
  - md_rf_we = (md_rd!=0); wb_sel_md=1.
  - RAW/WAW conflicts on md_rd still stall this cycle; the register file is read after the write completes.
  - Structural conflict is cleared, so a new issue is allowed here and goes straight to RUN. Otherwise go to IDLE.
- Other rules:
  - bubble_DE = stall_ID whenever stall_ID is asserted, so stalled ID never duplicates into EX.
  - ext_stall_ID never delays cnt. The reservation bubble is inserted even during an external stall; the OR of both requests is a single bubble.
  - Total latency: issue edge S to write cycle S+LAT.

Optional Feature:
- Macro: MUL_DIV_FWD_EN.
- With the macro: adds outputs fwd_md_A and fwd_md_B (1 bit each). In the WB state, a RAW match on rs1/rs2 asserts fwd_md_A/B and does not stall, so ID takes the operand from the result bus. WAW still stalls.
- Without the macro: the ports are absent, and RAW in WB stalls as described above.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - the FSM state enum (IDLE=2'b00, RUN=2'b01, WB=2'b10);
  - default MUL_LAT/DIV_LAT;
  - constant WB_RESERVE_DIST=3 (EX, MEM and WB stage distance).
- One natural sub-module, md_lat_counter: a load/decrement counter with a terminal flag at cnt==3 and cnt==1.

Test Plan:
1. MUL x5 issued at S, no dependents → md_start=1 at S only; stall_ID=bubble_DE=1 in cycle S+1; md_rf_we=1 with md_rd=5 in cycle S+4.
2. DIV x7 then ADD x8,x7,x1 in ID at S+1 → stall_ID held S+1..S+34; ADD enters EX at S+35 (S+34 with MUL_DIV_FWD_EN, fwd_md_A=1).
3. MUL x3 then MUL x4 immediately → second stalls until WB cycle S+4; second md_start at S+4, second write at S+8.
4. Reset asserted at S+10 during DIV → outputs 0 from next cycle; md_rf_we never asserted; a later MUL issues normally.
5. MUL x0 → full timing and bubble occur, md_rf_we=0 throughout; ADD reading x0 never stalls.
6. ext_stall_ID=1 while md_valid_ID=1 → no md_start; issue in the first cycle ext_stall_ID=0.
